jtag_reg_access: RTL and testbench
==================================

JTAG_REG_ACCESS -- requirements
Module: jtag_reg_access

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 15: write attempts lost to core writes before error; range 1..15.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  debug request valid
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1=write, 0=read
- req_addr  in  5  GPR index
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_rdata  out  32  read data
- resp_err  out  1  retry timeout or readback mismatch
- core_wen  in  1  core writeback enable (snoop)
- core_waddr  in  5  core writeback address (snoop)
- jtag_wen  out  1  regfile debug write enable
- jtag_addr  out  5  regfile debug address
- jtag_wdata  out  32  regfile debug write data
- jtag_rdata  in  32  regfile debug read data (combinational, x0 reads 0)
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL use FSM states IDLE, WR, VFY, RD, RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE; handshake = req_valid&req_ready; latch req_we/addr/wdata at handshake.
REQ-006 On write handshake to addr!=0, SHALL go to WR, clear retry count; on write to addr 0, SHALL go directly to RESP, err=0, no jtag_wen pulse.
REQ-007 On read handshake, SHALL go to RD.
REQ-008 In WR, SHALL drive jtag_wen=1, jtag_addr/jtag_wdata = latched values.
REQ-009 Collision = core_wen & (core_waddr!=0) in a WR cycle, regardless of core_waddr vs jtag_addr (regfile drops debug write).
REQ-010 On collision SHALL increment retry count, stay in WR; when count reaches MAX_RETRY, SHALL go to RESP with err=1.
REQ-011 With no collision, SHALL leave WR for VFY (if configured) else RESP with err=0.
REQ-012 In RD, SHALL hold jtag_addr, jtag_wen=0, capture jtag_rdata into resp_rdata at cycle end, go to RESP, err=0.
REQ-013 In RESP, SHALL hold resp_valid=1 and resp_rdata/resp_err stable until resp_ready; then IDLE next cycle.
REQ-014 Latency: handshake at cycle T, collision-free write or read -> resp_valid at T+2 (T+3 with VFY); each collision adds 1 cycle.
REQ-015 Write responses SHALL return resp_rdata = written data.
REQ-016 jtag_wen SHALL be 0 outside WR.

Reset
REQ-017 rst SHALL force IDLE, retry count 0, jtag_wen=0, jtag_addr=0, jtag_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 the cycle after.
REQ-018 rst mid-operation SHALL discard the pending request with no response and no further jtag_wen.

Configuration
REQ-019 With JTAG_REG_READBACK_EN defined, WR success SHALL go to VFY: one cycle, jtag_wen=0, compare jtag_rdata to latched wdata; mismatch -> err=1, resp_rdata = jtag_rdata; then RESP.
REQ-020 Without JTAG_REG_READBACK_EN, VFY SHALL be unreachable and not synthesized.

Structure
REQ-021 Address/data widths (RegAddrBus, RegBus), ZeroReg, ZeroWord and FSM state encodings SHALL live in the shared defines file.
REQ-022 SHALL be a single module with no sub-module.

Verification
REQ-023 Read x5 holding 0xDEADBEEF, resp_ready=1 -> resp_valid at T+2, rdata=0xDEADBEEF, err=0.
REQ-024 Write x7=0x12345678, no core writes -> one jtag_wen pulse at T+1, resp err=0; subsequent read returns 0x12345678.
REQ-025 Write x3 with core_wen=1, core_waddr=9 for 3 WR cycles -> 4 jtag_wen cycles, success on 4th, err=0.
REQ-026 MAX_RETRY=2, core_wen held with core_waddr=1 -> 2 WR cycles, resp err=1, x3 unchanged.
REQ-027 Write x0=0xFFFFFFFF -> no jtag_wen, resp err=0 at T+1; read x0 returns 0.
REQ-028 rst asserted during RESP with resp_ready=0 -> next cycle resp_valid=0, req_ready=1; with READBACK_EN, core writing same reg at VFY cycle -> err=1.

Source files
------------

// File: rtl/jtag_reg_access_pkg.sv
// Shared definitions for the JTAG debug register-file access block:
// bus widths, zero constants, FSM state encoding and the write-collision helper.
package jtag_reg_access_pkg;

   localparam int RegAddrBus = 5;
   localparam int RegBus     = 32;

   localparam logic [RegAddrBus-1:0] ZeroReg  = '0;
   localparam logic [RegBus-1:0]     ZeroWord = '0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      VFY  = 3'd2,
      RD   = 3'd3,
      RESP = 3'd4
   } state_e;

   // The regfile gives the core write port priority, so any real core write drops ours.
   function automatic logic is_collision(input logic                  wen,
                                         input logic [RegAddrBus-1:0] waddr);
      return wen && (waddr != ZeroReg);
   endfunction

endpackage

// File: rtl/jtag_reg_access.sv
// Debug-side GPR access engine: one request at a time, writes retried while the core
// owns the regfile write port. Define JTAG_REG_READBACK_EN to add a post-write verify cycle.
module jtag_reg_access
   import jtag_reg_access_pkg::*;
#(
   parameter int MAX_RETRY = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic        core_wen,
   input  logic [4:0]  core_waddr,
   output logic        jtag_wen,
   output logic [4:0]  jtag_addr,
   output logic [31:0] jtag_wdata,
   input  logic [31:0] jtag_rdata
);

   localparam logic [3:0] RetryLimit = 4'(MAX_RETRY);

   state_e      state, state_nxt;
   logic [3:0]  retry_cnt, retry_nxt;
   logic [3:0]  retry_inc;
   logic [4:0]  addr_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] rdata_nxt;
   logic        err_nxt;
   logic        collision;

   assign retry_inc  = retry_cnt + 4'd1;
   assign collision  = is_collision(core_wen, core_waddr);

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign jtag_wen   = (state == WR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         retry_cnt  <= 4'd0;
         jtag_addr  <= ZeroReg;
         jtag_wdata <= ZeroWord;
         resp_rdata <= ZeroWord;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         retry_cnt  <= retry_nxt;
         jtag_addr  <= addr_nxt;
         jtag_wdata <= wdata_nxt;
         resp_rdata <= rdata_nxt;
         resp_err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      addr_nxt  = jtag_addr;
      wdata_nxt = jtag_wdata;
      rdata_nxt = resp_rdata;
      err_nxt   = resp_err;
      case (state)
         IDLE: begin
            if (req_valid) begin
               addr_nxt  = req_addr;
               wdata_nxt = req_wdata;
               retry_nxt = 4'd0;
               err_nxt   = 1'b0;
               if (req_we) begin
                  // Write responses echo the data; x0 writes are acknowledged without touching the regfile.
                  rdata_nxt = req_wdata;
                  state_nxt = (req_addr == ZeroReg) ? RESP : WR;
               end else begin
                  state_nxt = RD;
               end
            end
         end
         WR: begin
            if (collision) begin
               retry_nxt = retry_inc;
               if (retry_inc == RetryLimit) begin
                  err_nxt   = 1'b1;
                  state_nxt = RESP;
               end
            end else begin
`ifdef JTAG_REG_READBACK_EN
               state_nxt = VFY;
`else
               state_nxt = RESP;
`endif
            end
         end
`ifdef JTAG_REG_READBACK_EN
         VFY: begin
            // A core write to the same register in this cycle would overwrite our value next edge.
            if ((jtag_rdata != jtag_wdata) || (collision && (core_waddr == jtag_addr))) begin
               err_nxt   = 1'b1;
               rdata_nxt = jtag_rdata;
            end
            state_nxt = RESP;
         end
`endif
         RD: begin
            rdata_nxt = jtag_rdata;
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jtag_reg_access.sv
// Directed bench for jtag_reg_access: default instance plus a MAX_RETRY=2 instance,
// each attached to its own behavioural register file.
module tb_jtag_reg_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, resp_ready, core_wen;
   logic [4:0]  req_addr, core_waddr;
   logic [31:0] req_wdata;

   logic        req_ready, resp_valid, resp_err, jtag_wen;
   logic [4:0]  jtag_addr;
   logic [31:0] jtag_wdata, jtag_rdata, resp_rdata;
   logic        req_ready_2, resp_valid_2, resp_err_2, jtag_wen_2;
   logic [4:0]  jtag_addr_2;
   logic [31:0] jtag_wdata_2, jtag_rdata_2, resp_rdata_2;

   logic        pre_en;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] regs  [32];
   logic [31:0] regs2 [32];
   localparam logic [31:0] CoreData = 32'hC0DE_0000;

   bit          sel;
   logic        s_req_ready, s_resp_valid, s_resp_err, s_jtag_wen;
   logic [31:0] s_resp_rdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jtag_reg_access dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .core_wen(core_wen), .core_waddr(core_waddr),
      .jtag_wen(jtag_wen), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata)
   );

   jtag_reg_access #(.MAX_RETRY(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_2), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_2), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata_2), .resp_err(resp_err_2), .core_wen(core_wen), .core_waddr(core_waddr),
      .jtag_wen(jtag_wen_2), .jtag_addr(jtag_addr_2), .jtag_wdata(jtag_wdata_2), .jtag_rdata(jtag_rdata_2)
   );

   // Register file: core write port wins, a colliding debug write is dropped.
   always @(posedge clk) begin
      if (pre_en) begin
         regs[pre_addr]  <= pre_data;
         regs2[pre_addr] <= pre_data;
      end else if (core_wen && core_waddr != 5'd0) begin
         regs[core_waddr]  <= CoreData | 32'(core_waddr);
         regs2[core_waddr] <= CoreData | 32'(core_waddr);
      end else begin
         if (jtag_wen && jtag_addr != 5'd0)     regs[jtag_addr]    <= jtag_wdata;
         if (jtag_wen_2 && jtag_addr_2 != 5'd0) regs2[jtag_addr_2] <= jtag_wdata_2;
      end
   end

   assign jtag_rdata   = (jtag_addr == 5'd0)   ? 32'd0 : regs[jtag_addr];
   assign jtag_rdata_2 = (jtag_addr_2 == 5'd0) ? 32'd0 : regs2[jtag_addr_2];

   assign s_req_ready  = sel ? req_ready_2  : req_ready;
   assign s_resp_valid = sel ? resp_valid_2 : resp_valid;
   assign s_resp_err   = sel ? resp_err_2   : resp_err;
   assign s_jtag_wen   = sel ? jtag_wen_2   : jtag_wen;
   assign s_resp_rdata = sel ? resp_rdata_2 : resp_rdata;

   typedef struct {
      bit          sel;
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      int          ncoll;
      logic [4:0]  caddr;
      int          lat;
      int          nwen;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic run(input vec_t v, input int idx);
      int lat = 0;
      int nwen = 0;
      logic [31:0] rd = 'x;
      logic er = 1'bx;
      sel = v.sel;
      check($sformatf("v%0d_ready", idx), 32'(s_req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         core_wen = (k <= v.ncoll); core_waddr = v.caddr;
         @(negedge clk);
         if (s_jtag_wen) nwen++;
         if (s_resp_valid) begin
            lat = k; rd = s_resp_rdata; er = s_resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat == 0) begin
         n_chk++; n_fail++;
         $display("FAIL v%0d_timeout: no resp_valid within 40 cycles", idx);
      end else begin
         check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
         check($sformatf("v%0d_wen_cycles", idx), 32'(nwen), 32'(v.nwen));
         check($sformatf("v%0d_rdata", idx), rd, v.rdata);
         check($sformatf("v%0d_err", idx), 32'(er), 32'(v.err));
      end
      @(posedge clk); #1;
      core_wen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (req_ready && req_ready_2) break;
         @(posedge clk); #1;
      end
      check($sformatf("v%0d_back_idle", idx), {30'd0, req_ready, req_ready_2}, 32'd3);
   endtask

   initial begin
      logic        seen;
      logic [31:0] held;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1; core_wen = 1'b0; core_waddr = '0; sel = 1'b0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;

      //             sel we  addr   wdata          ncoll caddr lat nwen rdata          err
      vecs[0]  = '{1'b0, 1'b0, 5'd5,  32'h0,         0,  5'd0,  2,  0, 32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 5'd7,  32'h12345678,  0,  5'd0,  2,  1, 32'h12345678, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 5'd7,  32'h0,         0,  5'd0,  2,  0, 32'h12345678, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 5'd3,  32'hCAFEF00D,  3,  5'd9,  5,  4, 32'hCAFEF00D, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 5'd3,  32'h0,         0,  5'd0,  2,  0, 32'hCAFEF00D, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,  0,  5'd0,  1,  0, 32'hFFFFFFFF, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         0,  5'd0,  2,  0, 32'h00000000, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 5'd10, 32'h0BADCAFE, 15,  5'd2, 16, 15, 32'h0BADCAFE, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 5'd11, 32'h11112222, 14,  5'd31,16, 15, 32'h11112222, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 5'd10, 32'h0,         0,  5'd0,  2,  0, 32'h10101010, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 5'd3,  32'hAAAA5555, 20,  5'd1,  3,  2, 32'hAAAA5555, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 5'd3,  32'h0,         0,  5'd0,  2,  0, 32'h33333333, 1'b0};

      @(posedge clk); #1;
      preload(5'd5,  32'hDEADBEEF);
      preload(5'd3,  32'h33333333);
      preload(5'd10, 32'h10101010);
      preload(5'd13, 32'h13131313);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_jtag_wen",   32'(jtag_wen),   32'd0);
      check("rst_jtag_addr",  32'(jtag_addr),  32'd0);
      check("rst_jtag_wdata", jtag_wdata,      32'd0);
      check("rst_resp_rdata", resp_rdata,      32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run(vecs[i], i);
      sel = 1'b0;

      // Response held while resp_ready is low, then discarded by reset.
      resp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd12; req_wdata = 32'h5A5A5A5A;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = resp_valid;
         if (!seen) begin @(posedge clk); #1; end
      end
      check("hold_resp_seen", 32'(seen), 32'd1);
      held = resp_rdata;
      check("hold_rdata_value", held, 32'h5A5A5A5A);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hold_valid_%0d", k), 32'(resp_valid), 32'd1);
         check($sformatf("hold_rdata_%0d", k), resp_rdata, held);
         check($sformatf("hold_err_%0d", k), 32'(resp_err), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("resp_rst_valid", 32'(resp_valid), 32'd0);
      check("resp_rst_ready", 32'(req_ready),  32'd1);
      check("resp_rst_rdata", resp_rdata,      32'd0);
      resp_ready = 1'b1;
      @(posedge clk); #1;

      // Reset while a write is stuck retrying: no response, no further write strobes.
      core_wen = 1'b1; core_waddr = 5'd4;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd13; req_wdata = 32'h99999999;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      check("wr_rst_wen_before", 32'(jtag_wen), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; core_wen = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (jtag_wen || resp_valid) seen = 1'b1;
      end
      check("wr_rst_quiet", 32'(seen), 32'd0);
      check("wr_rst_x13_kept", regs[13], 32'h13131313);
      check("wr_rst_ready", 32'(req_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
